// File: rtl/sd_pkg.sv
// Shared types and width helpers for the serial frame receiver.
package sd_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      PAR  = 2'd2,
      DONE = 2'd3
   } state_t;

   // Bit counter only has to reach W-1.
   function automatic int cnt_w(input int w);
      return $clog2(w);
   endfunction

   // Ones accumulator must hold W itself without wrapping.
   function automatic int acc_w(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/sd_serie_n_if.sv
// Serial input and decoded-word outputs of the frame receiver.
interface sd_serie_n_if
   import sd_pkg::*;
#(
   parameter int W = 8
);
   logic                  xs;
   logic                  en;
   logic                  fin;
   logic                  busy;
   logic [W-1:0]          dato;
   logic [acc_w(W)-1:0]   unos;
   logic                  err_par;

   modport master (output xs, en, input fin, busy, dato, unos, err_par);
   modport slave  (input xs, en, output fin, busy, dato, unos, err_par);
endinterface

// File: rtl/sd_serie_ud.sv
// Datapath unit: shift register, bit counter, ones accumulator, parity check
// and the held output registers.
module sd_serie_ud
   import sd_pkg::*;
#(
   parameter int  W          = 8,
   parameter bit  PARITY_ODD = 1'b0,
   localparam int CW         = cnt_w(W),
   localparam int AW         = acc_w(W)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          xs,
   input  logic          clr,
   input  logic          sh,
   input  logic          ld_par,
   input  logic          ld_out,
   output logic          ult,
   output logic          par_err,
   output logic [W-1:0]  dato,
   output logic [AW-1:0] unos
);

   logic [W-1:0]  shreg;
   logic [W-1:0]  shreg_nxt;
   logic [CW-1:0] cnt;
   logic [AW-1:0] acc;
   logic [AW-1:0] acc_nxt;
   logic          err_nxt;

   // Post-shift values, so the output load can include the last data bit
   // sampled in the same cycle.
   always_comb begin
      shreg_nxt = shreg;
      acc_nxt   = acc;
      if (sh) begin
         shreg_nxt = {xs, shreg[W-1:1]};
         acc_nxt   = acc + AW'(xs);
      end
   end

   // ld_par is only ever raised with parity framing, so err stays 0 otherwise.
   assign err_nxt = ld_par & ((acc[0] ^ xs) != PARITY_ODD);
   assign ult     = (cnt == CW'(W - 1));

   // Working registers plus output registers that only change on frame completion.
   always_ff @(posedge clk) begin
      if (reset) begin
         shreg   <= '0;
         cnt     <= '0;
         acc     <= '0;
         dato    <= '0;
         unos    <= '0;
         par_err <= 1'b0;
      end else begin
         if (clr) begin
            shreg <= '0;
            cnt   <= '0;
            acc   <= '0;
         end else if (sh) begin
            shreg <= shreg_nxt;
            cnt   <= cnt + CW'(1);
            acc   <= acc_nxt;
         end
         if (ld_out) begin
            dato    <= shreg_nxt;
            unos    <= acc_nxt;
            par_err <= err_nxt;
         end
      end
   end

endmodule

// File: rtl/sd_serie_n.sv
// Serial frame receiver: control unit FSM driving the sd_serie_ud datapath.
//
//   state | meaning
//   IDLE  | waiting for a start bit (en=1, xs=1)
//   DATA  | shifting in W data bits, LSB first
//   PAR   | waiting for the parity bit
//   DONE  | one-cycle completion, fin=1, outputs valid
module sd_serie_n
   import sd_pkg::*;
#(
   parameter int W          = 8,
   parameter bit PARITY_EN  = 1'b1,
   parameter bit PARITY_ODD = 1'b0
) (
   input  logic         clk,
   input  logic         reset,
   sd_serie_n_if.slave  bus
);

   state_t state;
   state_t state_nxt;
   logic   clr;
   logic   sh;
   logic   ld_par;
   logic   ld_out;
   logic   ult;
   logic   par_err;

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next state and datapath controls; ld_out fires on the transition into
   // DONE so outputs are valid while fin is high.
   always_comb begin
      state_nxt = state;
      clr       = 1'b0;
      sh        = 1'b0;
      ld_par    = 1'b0;
      ld_out    = 1'b0;
      case (state)
         IDLE: begin
            if (bus.en && bus.xs) begin
               clr       = 1'b1;
               state_nxt = DATA;
            end
         end
         DATA: begin
            if (bus.en) begin
               sh = 1'b1;
               if (ult) begin
                  if (PARITY_EN) begin
                     state_nxt = PAR;
                  end else begin
                     state_nxt = DONE;
                     ld_out    = 1'b1;
                  end
               end
            end
         end
         PAR: begin
            if (bus.en) begin
               ld_par    = 1'b1;
               ld_out    = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign bus.fin     = (state == DONE);
   assign bus.busy    = (state != IDLE);
   assign bus.err_par = par_err;

   sd_serie_ud #(
      .W          (W),
      .PARITY_ODD (PARITY_ODD)
   ) u_ud (
      .clk     (clk),
      .reset   (reset),
      .xs      (bus.xs),
      .clr     (clr),
      .sh      (sh),
      .ld_par  (ld_par),
      .ld_out  (ld_out),
      .ult     (ult),
      .par_err (par_err),
      .dato    (bus.dato),
      .unos    (bus.unos)
   );

endmodule

// File: tb/tb_sd_serie_n.sv
// Bench for sd_serie_n: three configurations (W=8 even, W=8 odd, W=4 no parity)
// share one stimulus source selected by sel.
module tb_sd_serie_n;

   logic clk = 1'b0;
   logic rst;
   logic xs_d;
   logic en_d;
   int   sel;
   int   checks   = 0;
   int   failures = 0;

   typedef struct {
      logic [31:0] d;
      int          u;
      bit          e;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   sd_serie_n_if #(.W(8)) b0 ();
   sd_serie_n_if #(.W(8)) b1 ();
   sd_serie_n_if #(.W(4)) b2 ();

   assign b0.xs = (sel == 0) ? xs_d : 1'b0;
   assign b0.en = (sel == 0) ? en_d : 1'b0;
   assign b1.xs = (sel == 1) ? xs_d : 1'b0;
   assign b1.en = (sel == 1) ? en_d : 1'b0;
   assign b2.xs = (sel == 2) ? xs_d : 1'b0;
   assign b2.en = (sel == 2) ? en_d : 1'b0;

   sd_serie_n #(.W(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut0 (.clk(clk), .reset(rst), .bus(b0));
   sd_serie_n #(.W(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) dut1 (.clk(clk), .reset(rst), .bus(b1));
   sd_serie_n #(.W(4), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut2 (.clk(clk), .reset(rst), .bus(b2));

   function automatic logic [31:0] o_dato(input int k);
      case (k)
         0:       return 32'(b0.dato);
         1:       return 32'(b1.dato);
         default: return 32'(b2.dato);
      endcase
   endfunction

   function automatic logic [31:0] o_unos(input int k);
      case (k)
         0:       return 32'(b0.unos);
         1:       return 32'(b1.unos);
         default: return 32'(b2.unos);
      endcase
   endfunction

   function automatic logic [31:0] o_fin(input int k);
      case (k)
         0:       return 32'(b0.fin);
         1:       return 32'(b1.fin);
         default: return 32'(b2.fin);
      endcase
   endfunction

   function automatic logic [31:0] o_busy(input int k);
      case (k)
         0:       return 32'(b0.busy);
         1:       return 32'(b1.busy);
         default: return 32'(b2.busy);
      endcase
   endfunction

   function automatic logic [31:0] o_err(input int k);
      case (k)
         0:       return 32'(b0.err_par);
         1:       return 32'(b1.err_par);
         default: return 32'(b2.err_par);
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Sends one frame to DUT k with `gap` en=0 cycles before every sample,
   // then checks fin timing and the decoded outputs against the scoreboard.
   task automatic run_frame(input int k, input logic [31:0] data, input int gap,
                            input bit p, input bit noise);
      int   nb;
      bit   hp;
      bit   odd;
      int   early;
      exp_t e;
      exp_t g;
      nb    = (k == 2) ? 4 : 8;
      hp    = (k != 2);
      odd   = (k == 1);
      e.d   = data & ((32'd1 << nb) - 32'd1);
      e.u   = $countones(e.d);
      e.e   = hp ? (((e.u + int'(p)) % 2) != int'(odd)) : 1'b0;
      sb.push_back(e);
      sel   = k;
      early = 0;
      en_d = 1'b1; xs_d = 1'b1;
      tick();
      if (o_fin(k) != 0) early++;
      for (int i = 0; i < nb; i++) begin
         for (int j = 0; j < gap; j++) begin
            en_d = 1'b0; xs_d = 1'($urandom);
            tick();
            if (o_fin(k) != 0) early++;
         end
         en_d = 1'b1; xs_d = data[i];
         tick();
         if ((i != nb - 1 || hp) && o_fin(k) != 0) early++;
      end
      if (hp) begin
         for (int j = 0; j < gap; j++) begin
            en_d = 1'b0; xs_d = 1'($urandom);
            tick();
            if (o_fin(k) != 0) early++;
         end
         en_d = 1'b1; xs_d = p;
         tick();
      end
      en_d = noise; xs_d = noise;
      chk("no_early_fin", early, 0);
      chk("fin_pulse", o_fin(k), 1);
      chk("busy_done", o_busy(k), 1);
      g = sb.pop_front();
      chk("dato", o_dato(k), g.d);
      chk("unos", o_unos(k), g.u);
      chk("err_par", o_err(k), 32'(g.e));
      tick();
      chk("fin_width", o_fin(k), 0);
      chk("busy_after", o_busy(k), 0);
      en_d = 1'b0; xs_d = 1'b0;
      tick();
      chk("idle_after", o_busy(k), 0);
      chk("dato_hold", o_dato(k), g.d);
   endtask

   initial begin
      int          noise_hits;
      logic [31:0] held;
      logic [31:0] rnd;
      sel  = 0;
      rst  = 1'b1;
      en_d = 1'b0;
      xs_d = 1'b0;
      repeat (3) tick();
      for (int k = 0; k < 3; k++) begin
         chk("rst_fin", o_fin(k), 0);
         chk("rst_busy", o_busy(k), 0);
         chk("rst_dato", o_dato(k), 0);
         chk("rst_unos", o_unos(k), 0);
         chk("rst_err", o_err(k), 0);
      end
      rst = 1'b0;
      tick();

      // Even parity, correct parity bit.
      run_frame(0, 32'hA5, 0, 1'b0, 1'b0);
      // Even parity, wrong parity bit.
      run_frame(0, 32'hA5, 0, 1'b1, 1'b0);
      // Odd parity, correct parity bit.
      run_frame(1, 32'hA5, 0, 1'b1, 1'b0);
      // Odd parity, wrong parity bit.
      run_frame(1, 32'hA5, 0, 1'b0, 1'b0);
      // en every 4th cycle, all ones: accumulator at its maximum.
      run_frame(0, 32'hFF, 3, 1'b0, 1'b0);

      // Outputs hold across idle time.
      held = o_dato(0);
      sel  = 0;
      repeat (10) tick();
      chk("hold_dato", o_dato(0), held);
      chk("hold_unos", o_unos(0), 8);

      // No parity, W=4, start-like noise in the DONE cycle.
      run_frame(2, 32'hB, 0, 1'b0, 1'b1);
      run_frame(2, 32'h6, 1, 1'b0, 1'b0);

      // Reset after 4 data bits.
      sel  = 0;
      en_d = 1'b1; xs_d = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) begin
         xs_d = 1'(i & 1);
         tick();
      end
      rst = 1'b1; en_d = 1'b1; xs_d = 1'b1;
      tick();
      chk("midrst_fin", o_fin(0), 0);
      chk("midrst_busy", o_busy(0), 0);
      chk("midrst_dato", o_dato(0), 0);
      chk("midrst_unos", o_unos(0), 0);
      chk("midrst_err", o_err(0), 0);
      repeat (2) tick();
      rst = 1'b0; en_d = 1'b0; xs_d = 1'b0;
      tick();
      chk("postrst_busy", o_busy(0), 0);
      run_frame(0, 32'h3C, 0, 1'b0, 1'b0);

      // Idle noise: zeros with en, then ones without en.
      sel        = 0;
      noise_hits = 0;
      for (int i = 0; i < 20; i++) begin
         en_d = 1'b1; xs_d = 1'b0;
         tick();
         if (o_busy(0) != 0 || o_fin(0) != 0) noise_hits++;
      end
      for (int i = 0; i < 5; i++) begin
         en_d = 1'b0; xs_d = 1'b1;
         tick();
         if (o_busy(0) != 0 || o_fin(0) != 0) noise_hits++;
      end
      chk("idle_noise", noise_hits, 0);
      en_d = 1'b0; xs_d = 1'b0;
      tick();

      // A few random frames on each configuration.
      for (int n = 0; n < 3; n++) begin
         rnd = $urandom;
         run_frame(0, rnd, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 1'b0);
         rnd = $urandom;
         run_frame(1, rnd, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 1'b0);
         rnd = $urandom;
         run_frame(2, rnd, int'($urandom_range(0, 2)), 1'b0, 1'($urandom_range(0, 1)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sd_serie_n.md
Name: sd_serie_n

Overview:
- Parametrised successor to the single-bit serial system SD: control unit plus datapath unit.
- Receives a framed serial word on xs: start bit, W data bits LSB-first, optional parity bit.
- Sampling is paced by an enable strobe (en). The block reports the word, its ones count and a parity error, and pulses fin for one cycle when the frame completes.
- Sits between a bit-rate tick generator and the consumer logic in the digital system top.

Parameters:
- W, 8, number of data bits per frame (2..32).
- PARITY_EN, 1, 1 = frame carries a parity bit after the data bits; 0 = no parity bit.
- PARITY_ODD, 0, 0 = even parity (data ones plus parity bit is even); 1 = odd parity.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- xs  in  1  serial data input, sampled only when en=1.
- en  in  1  sample strobe; one sample per cycle in which en=1.
- fin  out  1  one-cycle pulse: frame complete, outputs updated this cycle.
- busy  out  1  high from the start-bit sample until fin, inclusive.
- dato  out  W  last received word, LSB = first data bit.
- unos  out  $clog2(W+1)  number of 1s in dato.
- err_par  out  1  parity mismatch on last frame; 0 when PARITY_EN=0.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset values:
  - State is IDLE.
  - fin=0, busy=0, dato=0, unos=0, err_par=0.
  - Internal shift register, bit counter and ones accumulator are all cleared.
- FSM states are IDLE, DATA, PAR, DONE. Moore outputs: fin=1 only in DONE; busy=1 in DATA, PAR and DONE.
- IDLE:
  - en=1 and xs=1 is the start bit: go to DATA, clear the bit counter and the ones accumulator.
  - en=0, or en=1 with xs=0: stay in IDLE.
- DATA:
  - On en=1: shift xs into the MSB of the shift register (shift right), increment the counter, add xs to the ones accumulator.
  - When en=1 and counter == W-1: go to PAR if PARITY_EN=1, else DONE.
  - en=0 holds all state.
- PAR:
  - On en=1: sample the parity bit p and go to DONE.
  - err = (acc_ones[0] ^ p) != PARITY_ODD.
  - err is computed from the accumulator value including the final data bit.
- DONE:
  - Lasts exactly one cycle regardless of en.
  - dato, unos and err_par load from the datapath on entry, so they are valid in the same cycle fin=1.
  - Next state is IDLE unconditionally. An en=1 with xs=1 in the DONE cycle is ignored, not taken as a start bit.
- Output hold: dato, unos and err_par hold their values until the next DONE or reset. They never show partial frames.
- Latency (en=1 every cycle, start sampled at cycle t0):
  - data bits are sampled at t1..tW;
  - the parity bit at tW+1;
  - fin=1 at tW+2 (PARITY_EN=1) or tW+1 (PARITY_EN=0).
- Width rules:
  - The ones accumulator is $clog2(W+1) bits and never wraps; the maximum value W fits.
  - The bit counter is $clog2(W) bits and is compared against W-1.
- Reset mid-frame: reset wins over every transition. The block returns to IDLE with all outputs zero, and the partial frame is discarded.
- en gaps: any number of en=0 cycles between samples has no effect other than stalling.

Decomposition:
- Package sd_pkg:
  - state enum (IDLE, DATA, PAR, DONE), 2-bit encoding;
  - localparam helper for the count widths.
- Sub-module sd_serie_ud (datapath unit) holds:
  - shift register, bit counter and ones accumulator;
  - parity evaluator and output registers.
- Control/datapath interface:
  - the control unit (FSM in the top) drives clr, sh, ld_par and ld_out;
  - the datapath returns ult (counter == W-1) and par_err.
- Top instantiates sd_serie_ud with named connections.

Test Plan:
- Reset: assert reset 3 cycles mid-DATA after 4 data bits -> fin=0, busy=0, dato=0, unos=0 next cycle; the next complete frame decodes correctly.
- W=8, even parity, en=1 every cycle, send start, 1,0,1,0,0,1,0,1, p=0 -> fin=1 exactly at t10, dato=8'hA5, unos=4, err_par=0, busy low at t11.
- Same frame with p=1 -> dato=8'hA5, unos=4, err_par=1; PARITY_ODD=1 with p=1 -> err_par=0.
- en strobe every 4th cycle, frame 8'hFF with p=0 -> unos=8 (accumulator max value, no wrap), fin one cycle wide, dato=8'hFF; outputs stay stable between frames.
- PARITY_EN=0, W=4, data 1,1,0,1 -> fin at t5, dato=4'hB, unos=3, err_par=0. xs=1 with en=1 in the DONE cycle does not start a frame; busy=0 the following cycle.
- Idle noise: xs=0 with en=1 for 20 cycles, then xs=1 with en=0 -> stays IDLE, busy=0, no fin.
